rv_muldiv: RTL and testbench

Multi-cycle RV32M multiply/divide unit in the execute stage, beside the combinational ALU. The decoder routes every `opcode=0x33, funct7=0x01` instruction here instead of through the ALU's M path. This removes the 32-bit combinational divider from the critical path. Results return through a valid/ready handshake to the writeback mux, tagged with the destination register.

---
 rtl/rv_muldiv_pkg.sv | 18 +
 rtl/rv_div_core.sv | 67 ++++++
 rtl/rv_muldiv.sv | 145 ++++++++++++++
 tb/tb_rv_muldiv.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rv_muldiv_pkg.sv
// rv_muldiv_pkg: shared RV32M definitions.
//   XLEN     - default operand/result width (only 32 is supported)
//   F3_*     - funct3 encodings of the M extension, shared with ALU and decoder
//   state_e  - control state of the multi-cycle mul/div unit
package rv_muldiv_pkg;
  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_e;
endpackage

// File: rtl/rv_div_core.sv
// rv_div_core: restoring radix-2 unsigned divider, one quotient bit per step.
//   clk, rst_n        - clock, async active-low reset
//   load              - capture dividend/divisor magnitudes, clear remainder/counter
//   step              - perform one iteration (MSB first)
//   dividend, divisor - unsigned magnitudes
//   quo_nxt, rem_nxt  - quotient/remainder after the current step (combinational)
//   done              - current step is the last (counter == 31)
module rv_div_core #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quo_nxt,
  output logic [W-1:0] rem_nxt,
  output logic         done
);
  logic [W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [W:0]   shifted, diff;
  logic         qbit;

  // The quotient register doubles as the dividend shifter: its MSB feeds
  // the partial remainder while quotient bits enter at the LSB.
  always_comb begin
    shifted = {rem_q, quo_q[W-1]};
    diff    = shifted - {1'b0, dvs_q};
    qbit    = !diff[W];
    rem_nxt = qbit ? diff[W-1:0] : shifted[W-1:0];
    quo_nxt = {quo_q[W-2:0], qbit};
    done    = cnt_q == 5'd31;
  end

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = '0;
    end else if (step) begin
      rem_d = rem_nxt;
      quo_d = quo_nxt;
      cnt_d = cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/rv_muldiv.sv
// rv_muldiv: multi-cycle RV32M multiply/divide unit.
//   in_valid/in_ready  - request handshake (ready only in IDLE)
//   a, b, funct3       - rs1, rs2, M-extension operation
//   tag_in / tag_out   - destination register tag, passed through
//   flush              - kill any operation in flight (wins over accept/ready)
//   out_valid/out_ready- result handshake to writeback
//   result             - registered architectural result
module rv_muldiv import rv_muldiv_pkg::*; #(
  parameter int XLEN = rv_muldiv_pkg::XLEN,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      funct3,
  input  logic [TAGW-1:0] tag_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [TAGW-1:0] tag_out
);
  localparam int PW = 2 * XLEN;

  state_e          state_q, state_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2:0]      f3_q, f3_d;
  logic [TAGW-1:0] tag_q, tag_d;

  logic            accept, sgn_in, sgn_q, b_zero, ovf, spec_case;
  logic            div_load, div_step, div_done;
  logic [XLEN-1:0] spec_res, dvd_mag, dvs_mag, quo_nxt, rem_nxt;
  logic [XLEN-1:0] quo_fix, rem_fix, div_res, mul_res;
  logic            a_sx, b_sx;
  logic signed [XLEN:0]   mul_a, mul_b;
  logic signed [PW-1:0]   prod;

  assign in_ready  = state_q == ST_IDLE;
  assign out_valid = state_q == ST_DONE;
  assign result    = result_q;
  assign tag_out   = tag_q;
  assign accept    = in_valid && in_ready && !flush;

  // Divide special cases are decided on the live operands at accept time.
  // funct3[0]==0 marks the signed ops, funct3[1]==1 marks REM/REMU.
  assign sgn_in    = !funct3[0];
  assign b_zero    = b == '0;
  assign ovf       = sgn_in && (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b);
  assign spec_case = b_zero || ovf;
  assign spec_res  = b_zero ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : a);
  assign dvd_mag   = (sgn_in && a[XLEN-1]) ? -a : a;
  assign dvs_mag   = (sgn_in && b[XLEN-1]) ? -b : b;

  // 33x33 signed product; truncating to 64 bits keeps every result bit exact.
  assign a_sx    = (f3_q == F3_MULH) || (f3_q == F3_MULHSU);
  assign b_sx    = f3_q == F3_MULH;
  assign mul_a   = {a_sx & a_q[XLEN-1], a_q};
  assign mul_b   = {b_sx & b_q[XLEN-1], b_q};
  assign prod    = PW'(mul_a) * PW'(mul_b);
  assign mul_res = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[PW-1:XLEN];

  // Sign fix applied to the final step's output as the divide completes.
  assign sgn_q   = !f3_q[0];
  assign quo_fix = (sgn_q && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -quo_nxt : quo_nxt;
  assign rem_fix = (sgn_q && a_q[XLEN-1]) ? -rem_nxt : rem_nxt;
  assign div_res = f3_q[1] ? rem_fix : quo_fix;

  rv_div_core #(.W(XLEN)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (div_load),
    .step     (div_step),
    .dividend (dvd_mag),
    .divisor  (dvs_mag),
    .quo_nxt  (quo_nxt),
    .rem_nxt  (rem_nxt),
    .done     (div_done)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    f3_d     = f3_q;
    tag_d    = tag_q;
    result_d = result_q;
    div_load = 1'b0;
    div_step = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (accept) begin
          a_d   = a;
          b_d   = b;
          f3_d  = funct3;
          tag_d = tag_in;
          if (!funct3[2]) begin
            state_d = ST_MUL;
          end else if (spec_case) begin
            result_d = spec_res;
            state_d  = ST_DONE;
          end else begin
            div_load = 1'b1;
            state_d  = ST_DIV;
          end
        end
        ST_MUL: begin
          result_d = mul_res;
          state_d  = ST_DONE;
        end
        ST_DIV: begin
          div_step = 1'b1;
          if (div_done) begin
            result_d = div_res;
            state_d  = ST_DONE;
          end
        end
        ST_DONE: if (out_ready) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      f3_q     <= '0;
      tag_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      f3_q     <= f3_d;
      tag_q    <= tag_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_rv_muldiv.sv
module tb_rv_muldiv;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [2:0]  funct3;
  logic [4:0]  tag_in, tag_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rv_muldiv #(.XLEN(32), .TAGW(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .funct3(funct3), .tag_in(tag_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .tag_out(tag_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    case (f3)
      3'd0: begin p = 64'(ux * uy); return p[31:0]; end
      3'd1: begin p = 64'(sx * sy); return p[63:32]; end
      3'd2: begin p = 64'(sx * uy); return p[63:32]; end
      3'd3: begin p = 64'(ux * uy); return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFFFFFF;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return x;
        p = 64'(sx / sy); return p[31:0];
      end
      3'd5: begin
        if (y == 0) return 32'hFFFFFFFF;
        return x / y;
      end
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'd0;
        p = 64'(sx % sy); return p[31:0];
      end
      default: begin
        if (y == 0) return x;
        return x % y;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    if (f3 < 3'd4) return 2;
    if (y == 0) return 1;
    if (!f3[0] && x == 32'h80000000 && y == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  // Issue one op, measure latency, optionally stall in DONE for 'hold' cycles.
  task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] tg, input int hold);
    int          lat;
    logic [31:0] exp;
    logic        stable;
    exp = ref_op(f3, x, y);
    chk({nm, ".in_ready"}, 32'(in_ready), 32'd1);
    a = x; b = y; funct3 = f3; tag_in = tg; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; tag_in = 5'(~tg);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, ".latency"}, 32'(lat), 32'(ref_lat(f3, x, y)));
    chk({nm, ".result"}, result, exp);
    chk({nm, ".tag"}, 32'(tag_out), 32'(tg));
    if (hold > 0) begin
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (!out_valid || in_ready || result !== exp || tag_out !== tg) stable = 1'b0;
      end
      chk({nm, ".hold_stable"}, 32'(stable), 32'd1);
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk({nm, ".post_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic        seen;
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; funct3 = '0; tag_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.result", result, 32'd0);
    chk("rst.tag_out", 32'(tag_out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    run_op("mul7x6", 3'd0, 32'd7, 32'd6, 5'd3, 0);
    run_op("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 0);
    run_op("div_neg7_2", 3'd4, 32'hFFFFFFF9, 32'd2, 5'd5, 0);
    run_op("rem_neg7_2", 3'd6, 32'hFFFFFFF9, 32'd2, 5'd6, 0);
    run_op("remu", 3'd7, 32'hFFFFFFFF, 32'd10, 5'd7, 0);
    run_op("div_by0", 3'd4, 32'd42, 32'd0, 5'd8, 0);
    run_op("rem_by0", 3'd6, 32'd43, 32'd0, 5'd9, 0);
    run_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd10, 0);
    run_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd11, 0);
    run_op("mulh", 3'd1, 32'h80000000, 32'h80000000, 5'd12, 0);
    run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 0);
    run_op("stall", 3'd5, 32'd1000, 32'd7, 5'd14, 10);
    run_op("b2b", 3'd0, 32'd12, 32'd12, 5'd15, 0);

    // Flush mid-divide.
    a = 32'd1000; b = 32'd3; funct3 = 3'd4; tag_in = 5'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush.in_ready", 32'(in_ready), 32'd1);
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush.no_result", 32'(seen), 32'd0);
    run_op("after_flush", 3'd0, 32'd3, 32'd5, 5'd21, 0);

    // Reset mid-divide.
    a = 32'd99999; b = 32'd17; funct3 = 3'd5; tag_in = 5'd22; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("rstmid.out_valid", 32'(out_valid), 32'd0);
    chk("rstmid.result", result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstmid.in_ready", 32'(in_ready), 32'd1);
    chk("rstmid.tag_out", 32'(tag_out), 32'd0);

    // Flush together with in_valid in IDLE: not accepted.
    a = 32'd6; b = 32'd7; funct3 = 3'd0; tag_in = 5'd23; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_acc.in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush_acc.no_result", 32'(seen), 32'd0);

    // Randomized ops against the reference model.
    for (int i = 0; i < 60; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFFFFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h80000000;
      run_op("rand", rf3, ra, rb, 5'($urandom_range(0, 31)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
